// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_id_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: zero register, write bypass, then stored data/busy.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] i_id,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_id,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_busy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  logic w_is_zero;
  logic w_hit_wr;

  assign w_is_zero = (ZERO_REG != 0) && (i_id == '0);
  assign w_hit_wr  = (BYPASS != 0) && i_wr_en && (i_wr_id == i_id);

  // Zero register outranks bypass, which outranks the stored state.
  always_comb begin
    o_data = i_mem_data;
    o_busy = i_mem_busy;
    if (w_is_zero) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_hit_wr) begin
      o_data = i_wr_data;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Single-write, dual-read register file with per-register busy scoreboard
// and a live count of busy registers.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadRegID1,
  input  logic [ADDR_W-1:0] ReadRegID2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic              write,
  input  logic [ADDR_W-1:0] WriteRegID,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] ReserveRegID,
  output logic [ADDR_W:0]   BusyCount,
  output logic              WriteUnreserved
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;
  logic              r_wr_unres;

  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic              w_set;
  logic              w_clr;
  logic [DATA_W-1:0] w_mem_rd1;
  logic [DATA_W-1:0] w_mem_rd2;

  assign w_wr_ok  = write   && !((ZERO_REG != 0) && (WriteRegID   == '0));
  assign w_rsv_ok = reserve && !((ZERO_REG != 0) && (ReserveRegID == '0));

  // Count only real bit transitions; a same-id reserve cancels the clear.
  assign w_set = w_rsv_ok && !r_busy[ReserveRegID];
  assign w_clr = w_wr_ok && r_busy[WriteRegID] &&
                 !(w_rsv_ok && (ReserveRegID == WriteRegID));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_wr_unres <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[WriteRegID]  <= WriteData;
        r_busy[WriteRegID] <= 1'b0;
      end
      // Placed after the clear so a same-id reserve wins.
      if (w_rsv_ok) r_busy[ReserveRegID] <= 1'b1;
      r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr);
      r_wr_unres <= w_wr_ok && !r_busy[WriteRegID];
    end
  end

  assign w_mem_rd1 = r_mem[ReadRegID1];
  assign w_mem_rd2 = r_mem[ReadRegID2];

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd1 (
    .i_id       (ReadRegID1),
    .i_wr_en    (w_wr_ok),
    .i_wr_id    (WriteRegID),
    .i_wr_data  (WriteData),
    .i_mem_data (w_mem_rd1),
    .i_mem_busy (r_busy[ReadRegID1]),
    .o_data     (ReadData1),
    .o_busy     (ReadBusy1)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd2 (
    .i_id       (ReadRegID2),
    .i_wr_en    (w_wr_ok),
    .i_wr_id    (WriteRegID),
    .i_wr_data  (WriteData),
    .i_mem_data (w_mem_rd2),
    .i_mem_busy (r_busy[ReadRegID2]),
    .o_data     (ReadData2),
    .o_busy     (ReadBusy2)
  );

  assign BusyCount       = r_busy_cnt;
  assign WriteUnreserved = r_wr_unres;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share
// stimulus and are checked against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ReadRegID1, ReadRegID2, WriteRegID, ReserveRegID;
  logic        write, reserve;
  logic [31:0] WriteData;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        rb1_b, rb2_b, rb1_n, rb2_n;
  logic [5:0]  cnt_b, cnt_n;
  logic        wu_b, wu_n;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_wu;
  bit          m_valid = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .ReadRegID1(ReadRegID1), .ReadRegID2(ReadRegID2),
    .ReadData1(rd1_b), .ReadData2(rd2_b),
    .ReadBusy1(rb1_b), .ReadBusy2(rb2_b),
    .write(write), .WriteRegID(WriteRegID), .WriteData(WriteData),
    .reserve(reserve), .ReserveRegID(ReserveRegID),
    .BusyCount(cnt_b), .WriteUnreserved(wu_b)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .ReadRegID1(ReadRegID1), .ReadRegID2(ReadRegID2),
    .ReadData1(rd1_n), .ReadData2(rd2_n),
    .ReadBusy1(rb1_n), .ReadBusy2(rb2_n),
    .write(write), .WriteRegID(WriteRegID), .WriteData(WriteData),
    .reserve(reserve), .ReserveRegID(ReserveRegID),
    .BusyCount(cnt_n), .WriteUnreserved(wu_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] id, input bit byp);
    if (id == 0) return 32'h0;
    if (byp && write && WriteRegID == id) return WriteData;
    return m_mem[id];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] id, input bit byp);
    if (id == 0) return 32'h0;
    if (byp && write && WriteRegID == id) return 32'h0;
    return {31'h0, m_busy[id]};
  endfunction

  function automatic logic [31:0] exp_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_busy[i];
    return c;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_busy[i] = 0;
      end
      m_wu    = 0;
      m_valid = 1;
    end else begin
      m_wu = write && WriteRegID != 0 && !m_busy[WriteRegID];
      if (write && WriteRegID != 0) begin
        m_mem[WriteRegID]  = WriteData;
        m_busy[WriteRegID] = 0;
      end
      if (reserve && ReserveRegID != 0) m_busy[ReserveRegID] = 1;
    end
  endtask

  task automatic step(input logic rs, input logic wr, input logic [4:0] wid,
                      input logic [31:0] wd, input logic rv, input logic [4:0] rid,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst = rs; write = wr; WriteRegID = wid; WriteData = wd;
    reserve = rv; ReserveRegID = rid; ReadRegID1 = r1; ReadRegID2 = r2;
    #1;
    if (m_valid) begin
      chk("rd1_byp",  rd1_b, exp_data(r1, 1));
      chk("rd2_byp",  rd2_b, exp_data(r2, 1));
      chk("busy1_byp", {31'h0, rb1_b}, exp_busy(r1, 1));
      chk("busy2_byp", {31'h0, rb2_b}, exp_busy(r2, 1));
      chk("rd1_nobyp", rd1_n, exp_data(r1, 0));
      chk("rd2_nobyp", rd2_n, exp_data(r2, 0));
      chk("busy1_nobyp", {31'h0, rb1_n}, exp_busy(r1, 0));
      chk("busy2_nobyp", {31'h0, rb2_n}, exp_busy(r2, 0));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("count_byp",   {26'h0, cnt_b}, exp_count());
    chk("count_nobyp", {26'h0, cnt_n}, exp_count());
    chk("wunres_byp",   {31'h0, wu_b}, {31'h0, m_wu});
    chk("wunres_nobyp", {31'h0, wu_n}, {31'h0, m_wu});
  endtask

  initial begin
    rst = 1'b0; write = 1'b0; reserve = 1'b0; WriteData = '0;
    WriteRegID = '0; ReserveRegID = '0; ReadRegID1 = '0; ReadRegID2 = '0;

    // Reset, then fill registers with their own IDs
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++)
      step(0, 1, 5'(i), 32'(i), 0, 0, 5'(i), 5'(i - 1));
    step(0, 0, 0, 0, 0, 0, 1, 2);

    // Zero register ignores writes and reserves
    step(0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle bypass, then the stored value next cycle
    step(0, 1, 5, 32'h1234, 0, 0, 5, 5);
    step(0, 0, 0, 0, 0, 0, 5, 6);

    // Reserve 3,4,7, read busy 4, then write 4 to release it
    step(0, 0, 0, 0, 1, 3, 4, 3);
    step(0, 0, 0, 0, 1, 4, 4, 3);
    step(0, 0, 0, 0, 1, 7, 4, 7);
    step(0, 1, 4, 32'hA5A5, 0, 0, 4, 7);
    step(0, 0, 0, 0, 0, 0, 4, 7);

    // Write and reserve the same register on one edge, then reserve again
    step(0, 1, 9, 32'h55, 1, 9, 9, 9);
    step(0, 0, 0, 0, 1, 9, 9, 1);
    step(0, 1, 9, 32'h66, 0, 0, 9, 9);

    // Reserve everything: count saturates at 31, re-reserve is a no-op
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
    step(0, 0, 0, 0, 1, 31, 31, 30);
    for (int i = 31; i >= 0; i--) step(0, 1, 5'(i), 32'(i * 3), 0, 0, 5'(i), 1);

    // Reset discards pending reservations and the concurrent write
    step(0, 0, 0, 0, 1, 1, 1, 2);
    step(0, 0, 0, 0, 1, 2, 1, 2);
    step(0, 0, 0, 0, 1, 3, 2, 3);
    step(1, 1, 2, 32'hFF, 0, 0, 2, 3);
    step(0, 0, 0, 0, 0, 0, 2, 3);

    // Randomized traffic over a narrowed ID range to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wid, rid, a, b;
      wid = 5'($urandom_range(0, 11));
      rid = ($urandom_range(0, 3) == 0) ? wid : 5'($urandom_range(0, 11));
      a   = ($urandom_range(0, 2) == 0) ? wid : 5'($urandom_range(0, 31));
      b   = ($urandom_range(0, 2) == 0) ? rid : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), wid, $urandom,
           ($urandom_range(0, 2) != 0), rid, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the single-write, dual-read 32-bit register file, for the datapath decode/write-back stage.
- Adds a synchronous reset that clears storage.
- Adds an optional hardwired zero register.
- Adds optional write-to-read bypass.
- Adds a per-register busy scoreboard with a live busy count, so issue logic can detect pending producers.

Parameters:
DATA_W, 32, data width of every register
ADDR_W, 5, register-ID width; depth = 2**ADDR_W
ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes/reserves
BYPASS, 1, 1: a same-cycle write is forwarded to read ports combinationally

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
ReadRegID1  in  ADDR_W  read port 1 register ID
ReadRegID2  in  ADDR_W  read port 2 register ID
ReadData1  out  DATA_W  read port 1 data (combinational)
ReadData2  out  DATA_W  read port 2 data (combinational)
ReadBusy1  out  1  register on port 1 has a pending producer
ReadBusy2  out  1  register on port 2 has a pending producer
write  in  1  write enable
WriteRegID  in  ADDR_W  write register ID
WriteData  in  DATA_W  write data
reserve  in  1  mark register ReserveRegID busy (instruction issued)
ReserveRegID  in  ADDR_W  register to reserve
BusyCount  out  ADDR_W+1  number of busy registers
WriteUnreserved  out  1  registered 1-cycle pulse: last write targeted a non-busy register

Behaviour:
Reset and write timing:
- Reset: on rising edge with rst=1, all registers <= 0, busy <= 0, BusyCount <= 0, WriteUnreserved <= 0. rst overrides write/reserve in the same cycle.
- Write: at rising edge, if write=1 and not (ZERO_REG and WriteRegID==0), mem[WriteRegID] <= WriteData. Latency to a read without bypass: visible the cycle after the edge.

Read path (combinational, per port; precedence top-down):
1. ZERO_REG and ID==0 -> data 0, busy 0.
2. BYPASS and write and WriteRegID==ID -> data WriteData, busy 0.
3. Otherwise -> data mem[ID], busy busy[ID].
- Both ports may address the same register; both return identical values.

Scoreboard (per edge, rst=0):
- write to id w clears busy[w]; reserve to id r sets busy[r].
- Same id written and reserved in the same edge: reserve wins, busy stays 1, data still written.
- Reserve of an already-busy register: no change, no count increment.
- Reserve/write to reg 0 with ZERO_REG=1: ignored by the scoreboard.
- BusyCount: registered, next = current + set - cleared, computed from actual bit transitions only. Range 0..2**ADDR_W, or 2**ADDR_W-1 with ZERO_REG. No wrap.
- WriteUnreserved <= write and not busy[WriteRegID] (pre-edge value), excluding reg 0 when ZERO_REG. Advisory only; the write still occurs.

Other:
- No X propagation from uninitialised storage; registers are defined after the first reset.
- Reset mid-operation: every pending busy bit is discarded, and data written in the reset cycle is lost.

Decomposition:
- Shared package reg_file_pkg: default DATA_W/ADDR_W constants and the reg_id_t/reg_data_t typedefs.
- One sub-module, reg_file_read_port: zero, bypass and busy mux for a single port; instantiated twice.
- Storage, scoreboard and counter stay in the top.

Test Plan:
1. Reset, then write IDs 1..31 with data = ID, one per cycle; read ID1=1, ID2=2 -> ReadData1=1, ReadData2=2, busy 0, BusyCount=0.
2. Write ID0=0xDEADBEEF (ZERO_REG=1); read ID0 on both ports -> 0; WriteUnreserved stays 0.
3. Bypass: write ID5=0x1234 while reading ID5 in the same cycle -> ReadData1=0x1234 before the edge (BYPASS=1). With BYPASS=0 -> old value, then 0x1234 the next cycle.
4. Reserve IDs 3,4,7 on consecutive cycles -> BusyCount 1,2,3; ReadBusy1 on ID4=1. Write ID4 -> same-cycle ReadBusy1=0 (bypass), BusyCount=2 after the edge.
5. Same edge: reserve ID9 and write ID9=0x55 -> busy[9]=1, mem[9]=0x55, BusyCount+1, WriteUnreserved=1. Re-reserve ID9 -> BusyCount unchanged.
6. Reserve IDs 1..3, then assert rst with write ID2=0xFF in the same cycle -> BusyCount=0, all busy 0, ID2 reads 0.
